mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- Bus initiator that drives the main-memory side of the system bus: address[15:12] unit select, active-low nRead/nWrite, 256-bit data in each direction.
- Accepts single READ, single WRITE and multi-word COPY commands from the execute engine over a valid/ready handshake.
- Sequences the bus cycles so that main memory, which samples on negedge Clk, sees stable signals.
- Returns read data or a completion/error pulse.

Parameters:
- UNIT_ID, 4'h0, value driven on address[15:12] (main memory select).
- DATA_W, 256, bus data width.
- MAX_ADDR, 13, highest legal word index. Main memory holds 14 words.

Ports:
- Clk  in  1  system clock. All block logic is on posedge.
- nReset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_op  in  2  00 READ, 01 WRITE, 10 COPY, 11 reserved.
- cmd_addr  in  8  READ/WRITE word index; COPY source base.
- cmd_dst  in  8  COPY destination base.
- cmd_len  in  4  COPY word count.
- cmd_wdata  in  DATA_W  WRITE data.
- rsp_valid  out  1  one-cycle pulse; rsp_data valid.
- rsp_data  out  DATA_W  read result, held until the next read.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done. Set when the command was rejected.
- address  out  16  bus address, {UNIT_ID, 4'h0, word[7:0]}.
- nRead  out  1  bus read strobe, active low.
- nWrite  out  1  bus write strobe, active low.
- ExeDataOut  out  DATA_W  bus write data.
- MemDataOut  in  DATA_W  bus read data from memory.

Behaviour:
- Reset (async, any state) forces:
  - state IDLE, cmd_ready 1, rsp_valid 0, rsp_data 0, done 0, err 0.
  - address 0, nRead 1, nWrite 1, ExeDataOut 0.
  - Copy counters 0.
  - Reset mid-COPY aborts the copy; no done pulse.
- All outputs are registered except cmd_ready, which equals (state==IDLE).
- States:
  - IDLE: waits for accept.
  - RD: one cycle with nRead=0.
  - WR: one cycle with nWrite=0.
  - FIN: one cycle with done=1.
- Accept happens on the posedge where cmd_valid&&cmd_ready. Command fields are latched on that edge and ignored afterwards.
- Validation at accept. Any of the following goes IDLE->FIN with err=1 and no bus activity:
  - op 11.
  - READ/WRITE with addr>MAX_ADDR.
  - COPY with len==0.
  - COPY with src+len-1>MAX_ADDR or dst+len-1>MAX_ADDR (9-bit sums, no wrap).
- READ:
  - IDLE->RD, which drives address and nRead=0 for exactly one cycle.
  - Memory updates MemDataOut on the mid-cycle negedge.
  - On the posedge ending RD, the block captures MemDataOut into rsp_data and sets nRead=1.
  - Next state FIN with rsp_valid=1, done=1, err=0.
  - Accept-to-done: 2 cycles.
- WRITE:
  - IDLE->WR with address, ExeDataOut=wdata and nWrite=0 for one cycle.
  - Then FIN with done=1.
- COPY, for i=0..len-1:
  - RD at src+i; capture into an internal buffer (rsp_data unchanged, no rsp_valid).
  - WR at dst+i with ExeDataOut=buffer.
  - After the last WR, go to FIN.
  - Bus occupancy 2*len cycles; accept-to-done 2*len+1 cycles.
  - Overlapping src/dst ranges are copied in ascending order without correction; the result is defined by that order.
- Bus rules:
  - nRead and nWrite are never low in the same cycle.
  - Both are high in IDLE and FIN.
  - address and ExeDataOut hold their last values when idle.
- A cmd_valid arriving while busy is not accepted; cmd_ready=0. A command may be accepted on the same posedge that FIN->IDLE? No: FIN always returns to IDLE first, so there is a minimum 1 idle cycle between commands.

Test Plan:
- Reset, then READ addr 8 -> nRead low exactly 1 cycle, address 16'h0008; next cycle rsp_valid=1, rsp_data=256'h04, done=1, err=0.
- WRITE addr 3 data 256'hABCD, then READ addr 3 -> nWrite low 1 cycle; read returns 256'hABCD.
- COPY src 8 dst 10 len 2 -> bus alternates R8,W10,R9,W11; memory words 10/11 = 256'h04/256'h11; done 5 cycles after accept; no rsp_valid.
- Error cases: COPY src 12 len 3; READ addr 14; op 11; COPY len 0 -> each gives done=1, err=1 one cycle after accept, nRead/nWrite never low.
- Assert nReset during the WR cycle of COPY len 4 -> nWrite high immediately; outputs at reset values; following READ behaves normally.
- cmd_valid held high through a COPY -> second command accepted only after FIN+IDLE; bus checker asserts nRead&nWrite never both 0.

Source files
------------

// File: rtl/mem_bus_master_if.sv
// Command/response handshake and main-memory bus bundle for mem_bus_master.
//
// Handshake: a command transfers on the rising Clk edge where cmd_valid and
// cmd_ready are both high. The initiator holds cmd_valid and the command
// fields stable until that edge. cmd_ready drops while a command is running.
// rsp_valid and done are single-cycle pulses with no back-pressure.
interface mem_bus_master_if #(
  parameter int DATA_W = 256
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_addr;
  logic [7:0]        cmd_dst;
  logic [3:0]        cmd_len;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              done;
  logic              err;
  logic [15:0]       address;
  logic              nRead;
  logic              nWrite;
  logic [DATA_W-1:0] ExeDataOut;
  logic [DATA_W-1:0] MemDataOut;

  // Block side: takes commands and drives the memory bus.
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata, MemDataOut,
    output cmd_ready, rsp_valid, rsp_data, done, err,
    output address, nRead, nWrite, ExeDataOut
  );

  // Execute engine / memory side.
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata, MemDataOut,
    input  cmd_ready, rsp_valid, rsp_data, done, err,
    input  address, nRead, nWrite, ExeDataOut
  );
endinterface

// File: rtl/mem_bus_master.sv
// Main-memory bus initiator. Runs single READ / WRITE commands and multi-word
// COPY commands as a sequence of one-cycle RD and WR bus cycles. Memory samples
// on the falling edge, so every bus signal is registered on the rising edge and
// is stable across the mid-cycle sample point.
module mem_bus_master #(
  parameter logic [3:0] UNIT_ID  = 4'h0,
  parameter int         DATA_W   = 256,
  parameter int         MAX_ADDR = 13
) (
  input  logic              Clk,
  input  logic              nReset,
  mem_bus_master_if.master  bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [8:0] MAX9 = 9'(MAX_ADDR);

  state_t     state;
  logic       copy_mode;
  logic [7:0] src_ptr;
  logic [7:0] dst_ptr;
  logic [3:0] remaining;

  logic [8:0] src_end;
  logic [8:0] dst_end;
  logic       cmd_bad;

  function automatic logic [15:0] bus_addr(input logic [7:0] word);
    return {UNIT_ID, 4'h0, word};
  endfunction

  assign bus.cmd_ready = (state == IDLE);
  assign dbg_state     = state;

  // Last word touched by a COPY; 9 bits so a range past 255 cannot wrap.
  assign src_end = {1'b0, bus.cmd_addr} + {5'b0, bus.cmd_len} - 9'd1;
  assign dst_end = {1'b0, bus.cmd_dst}  + {5'b0, bus.cmd_len} - 9'd1;

  // Command validation, evaluated on the offered fields at the accept edge.
  always_comb begin
    cmd_bad = 1'b0;
    unique case (bus.cmd_op)
      2'b00, 2'b01: cmd_bad = ({1'b0, bus.cmd_addr} > MAX9);
      2'b10:        cmd_bad = (bus.cmd_len == 4'd0) || (src_end > MAX9) || (dst_end > MAX9);
      default:      cmd_bad = 1'b1;
    endcase
  end

  // Command sequencer; all bus and response outputs are registered here.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state          <= IDLE;
      copy_mode      <= 1'b0;
      src_ptr        <= 8'd0;
      dst_ptr        <= 8'd0;
      remaining      <= 4'd0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.address    <= 16'h0000;
      bus.nRead      <= 1'b1;
      bus.nWrite     <= 1'b1;
      bus.ExeDataOut <= '0;
    end else begin
      // Response strobes are single-cycle unless re-armed below.
      bus.rsp_valid <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            copy_mode <= 1'b0;
            if (cmd_bad) begin
              // Rejected commands never touch the bus.
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
              state    <= FIN;
            end else begin
              unique case (bus.cmd_op)
                2'b00: begin
                  bus.address <= bus_addr(bus.cmd_addr);
                  bus.nRead   <= 1'b0;
                  state       <= RD;
                end
                2'b01: begin
                  bus.address    <= bus_addr(bus.cmd_addr);
                  bus.ExeDataOut <= bus.cmd_wdata;
                  bus.nWrite     <= 1'b0;
                  state          <= WR;
                end
                default: begin
                  copy_mode   <= 1'b1;
                  src_ptr     <= bus.cmd_addr;
                  dst_ptr     <= bus.cmd_dst;
                  remaining   <= bus.cmd_len;
                  bus.address <= bus_addr(bus.cmd_addr);
                  bus.nRead   <= 1'b0;
                  state       <= RD;
                end
              endcase
            end
          end
        end
        RD: begin
          bus.nRead <= 1'b1;
          if (copy_mode) begin
            // The write-data register doubles as the copy buffer: the word
            // just read goes straight out on the following WR cycle.
            bus.ExeDataOut <= bus.MemDataOut;
            bus.address    <= bus_addr(dst_ptr);
            bus.nWrite     <= 1'b0;
            state          <= WR;
          end else begin
            bus.rsp_data  <= bus.MemDataOut;
            bus.rsp_valid <= 1'b1;
            bus.done      <= 1'b1;
            state         <= FIN;
          end
        end
        WR: begin
          bus.nWrite <= 1'b1;
          if (copy_mode && (remaining != 4'd1)) begin
            remaining   <= remaining - 4'd1;
            src_ptr     <= src_ptr + 8'd1;
            dst_ptr     <= dst_ptr + 8'd1;
            bus.address <= bus_addr(src_ptr + 8'd1);
            bus.nRead   <= 1'b0;
            state       <= RD;
          end else begin
            remaining <= 4'd0;
            bus.done  <= 1'b1;
            state     <= FIN;
          end
        end
        FIN: begin
          // Always pass through IDLE so commands are separated by one cycle.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a 14-word falling-edge memory model.
module tb_mem_bus_master;

  localparam int DW = 256;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [1:0] dbg_state;

  mem_bus_master_if #(.DATA_W(DW)) bus ();

  mem_bus_master #(
    .UNIT_ID (4'h0),
    .DATA_W  (DW),
    .MAX_ADDR(13)
  ) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .bus      (bus.master),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [0:13];
  logic [16:0]   bus_log [$];
  logic [16:0]   exp_q [$];
  int            done_cnt;
  int            rsp_cnt;

  // Memory model and bus monitor, both on the falling edge.
  always @(negedge Clk) begin
    if (!bus.nRead && bus.address[7:0] < 8'd14)
      bus.MemDataOut <= mem[bus.address[7:0]];
    if (!bus.nWrite && bus.address[7:0] < 8'd14)
      mem[bus.address[7:0]] <= bus.ExeDataOut;
    if (nReset) begin
      if (!bus.nRead)  bus_log.push_back({1'b0, bus.address});
      if (!bus.nWrite) bus_log.push_back({1'b1, bus.address});
      if (bus.done)      done_cnt++;
      if (bus.rsp_valid) rsp_cnt++;
      checks++;
      assert (!(!bus.nRead && !bus.nWrite)) else begin
        errors++;
        $error("FAIL bus_excl observed nRead=%0b nWrite=%0b expected not both 0",
               bus.nRead, bus.nWrite);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                      input logic [3:0] l, input logic [DW-1:0] wd, input bit hold);
    int n;
    @(negedge Clk);
    #1;
    bus_log.delete();
    done_cnt = 0;
    rsp_cnt  = 0;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_dst   = d;
    bus.cmd_len   = l;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=no_ready expected=ready");
    end
    @(posedge Clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // Cycle count includes the accept cycle; returns with done visible.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $error("FAIL done_timeout observed=no_done expected=done");
    end
  endtask

  // Let the response drain, then compare the bus log against exp_q.
  task automatic log_check(input string tag, input int exp_rsp);
    repeat (2) @(negedge Clk);
    #1;
    check({tag, "_len"}, DW'(bus_log.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < bus_log.size()) check($sformatf("%s_ev%0d", tag, i), DW'(bus_log[i]), DW'(exp_q[i]));
    end
    check({tag, "_done_cnt"}, DW'(done_cnt), DW'(1));
    check({tag, "_rsp_cnt"}, DW'(rsp_cnt), DW'(exp_rsp));
    exp_q.delete();
  endtask

  task automatic error_case(input string tag, input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] d, input logic [3:0] l);
    int cyc;
    send(op, a, d, l, '0, 1'b0);
    wait_done(cyc);
    check({tag, "_cyc"}, DW'(cyc), DW'(1));
    check({tag, "_err"}, DW'(bus.err), DW'(1));
    check({tag, "_rsp_valid"}, DW'(bus.rsp_valid), DW'(0));
    log_check(tag, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    for (int i = 0; i < 14; i++) mem[i] = DW'(256 + i);
    mem[8] = DW'(4);
    mem[9] = DW'(17);
    bus.MemDataOut = '0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b00;
    bus.cmd_addr   = 8'd0;
    bus.cmd_dst    = 8'd0;
    bus.cmd_len    = 4'd0;
    bus.cmd_wdata  = '0;
    done_cnt = 0;
    rsp_cnt  = 0;
    nReset = 1'b0;
    #12;
    check("rst_cmd_ready", DW'(bus.cmd_ready), DW'(1));
    check("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    check("rst_rsp_data", bus.rsp_data, '0);
    check("rst_done", DW'(bus.done), DW'(0));
    check("rst_err", DW'(bus.err), DW'(0));
    check("rst_address", DW'(bus.address), DW'(0));
    check("rst_nRead", DW'(bus.nRead), DW'(1));
    check("rst_nWrite", DW'(bus.nWrite), DW'(1));
    check("rst_exe_data", bus.ExeDataOut, '0);
    check("rst_state", DW'(dbg_state), DW'(0));
    @(negedge Clk);
    nReset = 1'b1;

    // READ 8
    send(2'b00, 8'd8, 8'd0, 4'd0, '0, 1'b0);
    check("rd8_nRead_low", DW'(bus.nRead), DW'(0));
    check("rd8_address", DW'(bus.address), DW'(16'h0008));
    wait_done(cyc);
    check("rd8_cyc", DW'(cyc), DW'(2));
    check("rd8_rsp_valid", DW'(bus.rsp_valid), DW'(1));
    check("rd8_rsp_data", bus.rsp_data, DW'(4));
    check("rd8_err", DW'(bus.err), DW'(0));
    check("rd8_nRead_high", DW'(bus.nRead), DW'(1));
    exp_q.push_back({1'b0, 16'h0008});
    log_check("rd8", 1);

    // WRITE 3 then READ 3
    send(2'b01, 8'd3, 8'd0, 4'd0, DW'(256'hABCD), 1'b0);
    check("wr3_nWrite_low", DW'(bus.nWrite), DW'(0));
    check("wr3_exe_data", bus.ExeDataOut, DW'(256'hABCD));
    wait_done(cyc);
    check("wr3_cyc", DW'(cyc), DW'(2));
    check("wr3_err", DW'(bus.err), DW'(0));
    exp_q.push_back({1'b1, 16'h0003});
    log_check("wr3", 0);
    check("wr3_mem", mem[3], DW'(256'hABCD));
    send(2'b00, 8'd3, 8'd0, 4'd0, '0, 1'b0);
    wait_done(cyc);
    check("rd3_rsp_data", bus.rsp_data, DW'(256'hABCD));
    exp_q.push_back({1'b0, 16'h0003});
    log_check("rd3", 1);

    // COPY 8 -> 10, len 2
    send(2'b10, 8'd8, 8'd10, 4'd2, '0, 1'b0);
    wait_done(cyc);
    check("cp_cyc", DW'(cyc), DW'(5));
    check("cp_err", DW'(bus.err), DW'(0));
    check("cp_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    exp_q.push_back({1'b0, 16'h0008});
    exp_q.push_back({1'b1, 16'h000A});
    exp_q.push_back({1'b0, 16'h0009});
    exp_q.push_back({1'b1, 16'h000B});
    log_check("cp", 0);
    check("cp_mem10", mem[10], DW'(4));
    check("cp_mem11", mem[11], DW'(17));
    check("cp_rsp_data_kept", bus.rsp_data, DW'(256'hABCD));

    // Boundary: COPY ending exactly on the last word, READ of the last word
    send(2'b10, 8'd12, 8'd0, 4'd2, '0, 1'b0);
    wait_done(cyc);
    check("cpedge_cyc", DW'(cyc), DW'(5));
    check("cpedge_err", DW'(bus.err), DW'(0));
    exp_q.push_back({1'b0, 16'h000C});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b0, 16'h000D});
    exp_q.push_back({1'b1, 16'h0001});
    log_check("cpedge", 0);
    check("cpedge_mem0", mem[0], DW'(268));
    check("cpedge_mem1", mem[1], DW'(269));
    send(2'b00, 8'd13, 8'd0, 4'd0, '0, 1'b0);
    wait_done(cyc);
    check("rd13_err", DW'(bus.err), DW'(0));
    check("rd13_rsp_data", bus.rsp_data, DW'(269));
    exp_q.push_back({1'b0, 16'h000D});
    log_check("rd13", 1);

    // Rejected commands
    error_case("e_cp_src", 2'b10, 8'd12, 8'd0, 4'd3);
    error_case("e_rd14", 2'b00, 8'd14, 8'd0, 4'd0);
    error_case("e_op3", 2'b11, 8'd0, 8'd0, 4'd1);
    error_case("e_cp_len0", 2'b10, 8'd0, 8'd2, 4'd0);
    error_case("e_cp_dst", 2'b10, 8'd0, 8'd13, 4'd2);
    error_case("e_wr14", 2'b01, 8'd14, 8'd0, 4'd0);

    // Reset during the first WR cycle of COPY 0 -> 4, len 4
    send(2'b10, 8'd0, 8'd4, 4'd4, '0, 1'b0);
    @(posedge Clk);
    #1;
    check("abort_pre_nWrite", DW'(bus.nWrite), DW'(0));
    check("abort_pre_address", DW'(bus.address), DW'(16'h0004));
    nReset = 1'b0;
    #1;
    check("abort_nWrite", DW'(bus.nWrite), DW'(1));
    check("abort_nRead", DW'(bus.nRead), DW'(1));
    check("abort_address", DW'(bus.address), DW'(0));
    check("abort_exe_data", bus.ExeDataOut, '0);
    check("abort_cmd_ready", DW'(bus.cmd_ready), DW'(1));
    check("abort_rsp_data", bus.rsp_data, '0);
    check("abort_state", DW'(dbg_state), DW'(0));
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("abort_no_done", DW'(done_cnt), DW'(0));
    check("abort_mem4", mem[4], DW'(260));
    check("abort_log_len", DW'(bus_log.size()), DW'(1));
    send(2'b00, 8'd9, 8'd0, 4'd0, '0, 1'b0);
    wait_done(cyc);
    check("post_rd9_cyc", DW'(cyc), DW'(2));
    check("post_rd9_data", bus.rsp_data, DW'(17));
    exp_q.push_back({1'b0, 16'h0009});
    log_check("post_rd9", 1);

    // cmd_valid held through a COPY; fields change after accept
    send(2'b10, 8'd8, 8'd12, 4'd2, '0, 1'b1);
    bus.cmd_op   = 2'b00;
    bus.cmd_addr = 8'd9;
    bus.cmd_len  = 4'd0;
    check("hold_busy_ready", DW'(bus.cmd_ready), DW'(0));
    wait_done(cyc);
    check("hold_cp_cyc", DW'(cyc), DW'(5));
    check("hold_cp_err", DW'(bus.err), DW'(0));
    check("hold_fin_ready", DW'(bus.cmd_ready), DW'(0));
    @(posedge Clk);
    #1;
    check("hold_idle_state", DW'(dbg_state), DW'(0));
    check("hold_idle_nRead", DW'(bus.nRead), DW'(1));
    @(posedge Clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("hold_rd_state", DW'(dbg_state), DW'(1));
    check("hold_rd_address", DW'(bus.address), DW'(16'h0009));
    wait_done(cyc);
    check("hold_rd_cyc", DW'(cyc), DW'(2));
    check("hold_rd_data", bus.rsp_data, DW'(17));
    exp_q.push_back({1'b0, 16'h0008});
    exp_q.push_back({1'b1, 16'h000C});
    exp_q.push_back({1'b0, 16'h0009});
    exp_q.push_back({1'b1, 16'h000D});
    exp_q.push_back({1'b0, 16'h0009});
    repeat (2) @(negedge Clk);
    #1;
    check("hold_log_len", DW'(bus_log.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < bus_log.size()) check($sformatf("hold_ev%0d", i), DW'(bus_log[i]), DW'(exp_q[i]));
    end
    exp_q.delete();
    check("hold_mem12", mem[12], DW'(4));
    check("hold_mem13", mem[13], DW'(17));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
